// File: rtl/sw_target_feeder.sv
// sw_target_feeder: left-boundary driver for the Smith-Waterman PE array.
// Buffers an upstream target sequence, streams it into the first PE as one
// contiguous enable burst, then waits on the last PE to report the final score.
// Optional feature macro: SW_FEEDER_WATCHDOG_EN (DRAIN timeout watchdog).
module sw_target_feeder #(
  parameter int SCORE_WIDTH = 12,
  parameter int ADDR_WIDTH  = 8,
  parameter logic [SCORE_WIDTH-1:0] ZERO = {1'b1, {(SCORE_WIDTH-1){1'b0}}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [1:0]             s_base,
  input  logic                   s_last,
  output logic                   pe_en,
  output logic [1:0]             pe_data,
  output logic [SCORE_WIDTH-1:0] pe_M,
  output logic [SCORE_WIDTH-1:0] pe_I,
  output logic [SCORE_WIDTH-1:0] pe_High,
  input  logic                   arr_en,
  input  logic [SCORE_WIDTH-1:0] arr_high,
  output logic                   busy,
  output logic                   res_vld,
  output logic [SCORE_WIDTH-1:0] res_score,
  output logic                   res_trunc
);

  localparam int MAX_LEN = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LEN_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PRIME,
    STREAM,
    GAP,
    DRAIN
  } state_t;

  state_t state_q, state_d;
  logic [ADDR_WIDTH:0] len_q, len_d;
  logic [ADDR_WIDTH:0] rd_q, rd_d;
  logic trunc_q, trunc_d;
  logic seenHigh_q, seenHigh_d;
  logic resVld_q, resVld_d;
  logic [SCORE_WIDTH-1:0] resScore_q, resScore_d;
  logic resTrunc_q, resTrunc_d;
  logic [1:0] rdData_q;
  logic [1:0] seqMem [MAX_LEN];
  logic wrEn;
  logic [ADDR_WIDTH-1:0] wrAddr;
  logic [ADDR_WIDTH-1:0] rdAddr;
  logic handshake;

`ifdef SW_FEEDER_WATCHDOG_EN
  logic [ADDR_WIDTH+3:0] wdog_q, wdog_d;
  logic [ADDR_WIDTH+3:0] wdogInc;
`endif

  assign s_ready   = (state_q == IDLE) || (state_q == LOAD);
  assign handshake = s_valid & s_ready;
  assign pe_en     = (state_q == STREAM);
  assign pe_data   = pe_en ? rdData_q : 2'b00;
  assign pe_M      = ZERO;
  assign pe_I      = ZERO;
  assign pe_High   = ZERO;
  assign busy      = (state_q != IDLE);
  assign res_vld   = resVld_q;
  assign res_score = resScore_q;
  assign res_trunc = resTrunc_q;

  // Next-state logic: sequence capture, contiguous streaming and completion detection
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    rd_d       = rd_q;
    trunc_d    = trunc_q;
    seenHigh_d = seenHigh_q;
    resVld_d   = 1'b0;
    resScore_d = resScore_q;
    resTrunc_d = resTrunc_q;
    wrEn       = 1'b0;
    wrAddr     = len_q[ADDR_WIDTH-1:0];
    rdAddr     = rd_q[ADDR_WIDTH-1:0] + ADDR_ONE;
`ifdef SW_FEEDER_WATCHDOG_EN
    wdog_d  = wdog_q;
    wdogInc = wdog_q + {{(ADDR_WIDTH+3){1'b0}}, 1'b1};
`endif
    case (state_q)
      IDLE: begin
        if (handshake) begin
          wrEn    = 1'b1;
          wrAddr  = '0;
          len_d   = LEN_ONE;
          trunc_d = 1'b0;
          state_d = s_last ? PRIME : LOAD;
        end
      end
      LOAD: begin
        if (handshake) begin
          if (len_q == LEN_FULL) begin
            trunc_d = 1'b1;
          end else begin
            wrEn  = 1'b1;
            len_d = len_q + LEN_ONE;
          end
          if (s_last) begin
            state_d = PRIME;
          end
        end
      end
      PRIME: begin
        rdAddr  = '0;
        rd_d    = '0;
        state_d = STREAM;
      end
      STREAM: begin
        if (rd_q == len_q - LEN_ONE) begin
          state_d = GAP;
        end else begin
          rd_d = rd_q + LEN_ONE;
        end
      end
      GAP: begin
        seenHigh_d = 1'b0;
`ifdef SW_FEEDER_WATCHDOG_EN
        wdog_d = '0;
`endif
        state_d = DRAIN;
      end
      DRAIN: begin
        if (arr_en) begin
          seenHigh_d = 1'b1;
        end
        if (!arr_en && seenHigh_q) begin
          resScore_d = arr_high;
          resTrunc_d = trunc_q;
          resVld_d   = 1'b1;
          state_d    = IDLE;
        end
`ifdef SW_FEEDER_WATCHDOG_EN
        else if (&wdogInc) begin
          resScore_d = ZERO;
          resTrunc_d = 1'b1;
          resVld_d   = 1'b1;
          state_d    = IDLE;
        end else begin
          wdog_d = wdogInc;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      rd_q       <= '0;
      trunc_q    <= 1'b0;
      seenHigh_q <= 1'b0;
      resVld_q   <= 1'b0;
      resScore_q <= ZERO;
      resTrunc_q <= 1'b0;
`ifdef SW_FEEDER_WATCHDOG_EN
      wdog_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      rd_q       <= rd_d;
      trunc_q    <= trunc_d;
      seenHigh_q <= seenHigh_d;
      resVld_q   <= resVld_d;
      resScore_q <= resScore_d;
      resTrunc_q <= resTrunc_d;
`ifdef SW_FEEDER_WATCHDOG_EN
      wdog_q     <= wdog_d;
`endif
    end
  end

  // Sequence buffer: write on accepted bases, registered read feeds pe_data
  always_ff @(posedge clk) begin
    if (wrEn) begin
      seqMem[wrAddr] <= s_base;
    end
    rdData_q <= seqMem[rdAddr];
  end

endmodule
